sprite_move_sched: RTL
======================

Name: sprite_move_sched

Overview:
- Sequencer that drives one W×H rectangular sprite leftward across the 160×120 VGA framebuffer.
- On each frame tick it erases the sprite at its old position, steps x left, and redraws it.
- It emits one pixel write per cycle (x, y, colour, plot) straight to the VGA adapter's write port.
- It replaces ad-hoc erase/draw control and owns all pixel-write sequencing for the sprite.

Parameters:
- W, 4, sprite width in pixels (1..16)
- H, 4, sprite height in pixels (1..16)
- X_START, 156, x of sprite's left column after start/wrap (0..159)
- STEP, 1, pixels moved left per tick (1..15)
- BG_COLOUR, 3'b000, colour written when erasing

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous active-low reset
- start  in  1  level; sampled only in IDLE; begins a run
- frame_tick  in  1  one-cycle pulse per frame (1/60 s), from the slow counter
- y_in  in  7  sprite top row, latched on start
- colour_in  in  3  sprite colour, latched on start
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  write strobe; x/y/colour valid when high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sprite has left the screen

Behaviour:
- Reset (resetn low at posedge):
  - state=IDLE; plot=0, done=0, busy=0, vga_x=0, vga_y=0, vga_colour=0.
  - x_pos=X_START; tick_pending=0; scan counters 0.
  - Reset dominates every state; an interrupted scan is abandoned and not resumed.
- Outputs are all registered. plot is high in exactly the cycles that carry a valid pixel.
- States: IDLE, DRAW, WAIT, ERASE, MOVE, DONE.
- IDLE:
  - start=1 latches y_base = min(y_in, 120-H) and colour_in.
  - Sets x_pos=X_START and goes to DRAW.
  - First plot appears in the cycle after start is sampled.
- DRAW / ERASE scan:
  - W*H consecutive cycles, one pixel each, row-major: dx inner 0..W-1, dy outer 0..H-1.
  - vga_x = x_pos+dx (8-bit); vga_y = y_base+dy.
  - vga_colour = latched colour in DRAW, BG_COLOUR in ERASE.
  - Clipping: if x_pos+dx > 159 the cycle still elapses but plot=0.
  - After the last pixel: DRAW→WAIT, ERASE→MOVE.
- WAIT:
  - Go to ERASE when frame_tick=1 or tick_pending=1.
  - tick_pending clears on the WAIT→ERASE transition.
- Ticks during DRAW/ERASE/MOVE set tick_pending. Pending is one bit: multiple ticks collapse to one; extra ticks are dropped.
- MOVE (1 cycle, plot=0):
  - If x_pos < STEP: go to DONE.
  - Else x_pos <= x_pos - STEP, then DRAW.
  - No underflow ever occurs.
- DONE (1 cycle): done=1, then IDLE. tick_pending is cleared.
- Frame latency per tick: 2*W*H+1 cycles plot-active window (33 for defaults), from ERASE entry to WAIT entry.
- start is ignored while busy=1. frame_tick is ignored in IDLE.

Optional Feature:
- Macro SPRITE_WRAP_EN.
- Defined: MOVE with x_pos < STEP sets x_pos=X_START and goes to DRAW. The sprite loops forever; done is never asserted; the run ends only by reset.
- Undefined: MOVE behaves as described in Behaviour (→DONE→IDLE).

Test Plan:
- Initial draw: defaults, y_in=50, colour_in=3'b100, start 1 cycle.
  - Expect 16 consecutive plot cycles: first (156,50,4), fifth (156,51,4), last (159,53,4).
  - Then plot=0, busy=1, done=0.
- One tick:
  - Expect 16 plots colour 0 covering x 156..159, y 50..53.
  - Then 1 idle cycle (MOVE), then 16 plots colour 4 covering x 155..158.
  - Then WAIT.
- Exit and clamp: y_in=118 clamps y_base to 116.
  - With x_pos=0, one tick → 16 erase plots at x 0..3, y 116..119, then MOVE.
  - Then done=1 for exactly 1 cycle; then busy=0, IDLE.
- Tick queuing: assert frame_tick 3 times during a DRAW scan.
  - Exactly one extra erase/draw pass starts the cycle after DRAW ends (WAIT lasts 1 cycle).
  - No second queued pass follows.
- Clipping: X_START=158, W=4.
  - Initial draw has 16 scan cycles; plot=1 only for x 158 and 159 (8 plots); no plot with x>159.
- Reset mid-ERASE: drop resetn for 1 cycle at pixel 7.
  - Next cycle plot=0, busy=0, x_pos=X_START; no further plots until a new start.
  - With SPRITE_WRAP_EN, the exit tick instead redraws at x 156..159 and done stays 0.

Source files
------------

// File: rtl/sprite_move_sched.sv
// Moves one W x H sprite leftward across the 160x120 framebuffer, one pixel write per cycle.
// Build option: SPRITE_WRAP_EN makes the sprite re-enter at X_START instead of finishing.
module sprite_move_sched #(
    parameter int         W         = 4,
    parameter int         H         = 4,
    parameter int         X_START   = 156,
    parameter int         STEP      = 1,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_DONE
    } state_t;

    localparam logic [3:0] DX_LAST = 4'(W - 1);
    localparam logic [3:0] DY_LAST = 4'(H - 1);
    localparam logic [6:0] Y_MAX   = 7'(120 - H);
    localparam logic [7:0] X_INIT  = 8'(X_START);
    localparam logic [7:0] X_STEP  = 8'(STEP);

    state_t     state_q, state_d;
    logic [7:0] x_pos_q, x_pos_d;
    logic [6:0] y_base_q, y_base_d;
    logic [2:0] colour_q, colour_d;
    logic [3:0] dx_q, dx_d;
    logic [3:0] dy_q, dy_d;
    logic       pending_q, pending_d;

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       last_px;
    logic [8:0] px_sum;

    assign last_px = (dx_q == DX_LAST) && (dy_q == DY_LAST);

    always_comb begin
        state_d   = state_q;
        x_pos_d   = x_pos_q;
        y_base_d  = y_base_q;
        colour_d  = colour_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_base_d = (y_in > Y_MAX) ? Y_MAX : y_in;
                    colour_d = colour_in;
                    x_pos_d  = X_INIT;
                    dx_d     = '0;
                    dy_d     = '0;
                    state_d  = S_DRAW;
                end
            end
            S_DRAW, S_ERASE: begin
                if (frame_tick) pending_d = 1'b1;
                if (last_px) begin
                    dx_d    = '0;
                    dy_d    = '0;
                    state_d = (state_q == S_DRAW) ? S_WAIT : S_MOVE;
                end else if (dx_q == DX_LAST) begin
                    dx_d = '0;
                    dy_d = dy_q + 4'd1;
                end else begin
                    dx_d = dx_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (frame_tick || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = S_ERASE;
                end
            end
            S_MOVE: begin
                if (frame_tick) pending_d = 1'b1;
                if (x_pos_q < X_STEP) begin
`ifdef SPRITE_WRAP_EN
                    x_pos_d = X_INIT;
                    state_d = S_DRAW;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    x_pos_d = x_pos_q - X_STEP;
                    state_d = S_DRAW;
                end
            end
            S_DONE: begin
                pending_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so each registered pixel lines up
    // with the state that owns it (first plot lands the cycle after start).
    always_comb begin
        px_sum       = 9'(x_pos_d) + 9'(dx_d);
        vga_x_d      = px_sum[7:0];
        vga_y_d      = y_base_d + 7'(dy_d);
        vga_colour_d = (state_d == S_ERASE) ? BG_COLOUR : colour_d;
        plot_d       = ((state_d == S_DRAW) || (state_d == S_ERASE)) && (px_sum <= 9'd159);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x_pos_q      <= X_INIT;
            y_base_q     <= '0;
            colour_q     <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            pending_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_pos_q      <= x_pos_d;
            y_base_q     <= y_base_d;
            colour_q     <= colour_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            pending_q    <= pending_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
